// File: rtl/sm_arith_pkg.sv
// Shared types and sign-magnitude helpers for the sequential multiplier.
// Widths depend on module parameters, so the helpers take them as arguments.
package sm_arith_pkg;

  typedef enum logic [1:0] {IDLE, CALC, ZERO, DONE} state_t;

  // Widest operand magnitude the field-extract helpers support.
  localparam int MAX_W = 64;

  function automatic int prd_w(input int mag_w);
    return 2 * mag_w + 1;
  endfunction

  function automatic int n_iter(input int mag_w, input int step);
    return mag_w / step;
  endfunction

  function automatic logic sm_sign(input logic [MAX_W:0] x, input int mag_w);
    return x[mag_w];
  endfunction

  function automatic logic [MAX_W-1:0] sm_mag(input logic [MAX_W:0] x, input int mag_w);
    logic [MAX_W-1:0] res;
    res = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < mag_w) res[i] = x[i];
    return res;
  endfunction

endpackage

// File: rtl/sm_mult_step.sv
// Combinational shift-add slice: retires STEP multiplier bits into the accumulator.
module sm_mult_step #(
  parameter int MAG_W = 8,
  parameter int STEP  = 1
) (
  input  logic [2*MAG_W-1:0] mcand,
  input  logic [STEP-1:0]    mplier_lo,
  input  logic [2*MAG_W-1:0] acc,
  output logic [2*MAG_W-1:0] acc_next
);

  always_comb begin
    acc_next = acc;
    for (int i = 0; i < STEP; i++)
      if (mplier_lo[i]) acc_next = acc_next + (mcand << i);
  end

endmodule

// File: rtl/sm_mult_seq.sv
// Sequential sign-magnitude multiplier with valid/ready on both sides.
// The magnitude is built by shift-add STEP bits per cycle; zero operands skip straight to the result.
module sm_mult_seq
  import sm_arith_pkg::*;
#(
  parameter int MAG_W = 8,
  parameter int STEP  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MAG_W:0]           a,
  input  logic [MAG_W:0]           b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [prd_w(MAG_W)-1:0]  prdct,
  output logic                     busy
);

  localparam int PRD_W  = prd_w(MAG_W);
  localparam int N_ITER = n_iter(MAG_W, STEP);
  localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N_ITER - 1);

  state_t             state;
  logic               sign_r;
  logic [2*MAG_W-1:0] mcand;
  logic [MAG_W-1:0]   mplier;
  logic [2*MAG_W-1:0] acc;
  logic [2*MAG_W-1:0] acc_next;
  logic [CNT_W-1:0]   cnt;

  logic [MAX_W-1:0] a_mag_full;
  logic [MAX_W-1:0] b_mag_full;
  logic [MAG_W-1:0] a_mag;
  logic [MAG_W-1:0] b_mag;
  logic             sign_in;
  logic             zero_in;
  logic             accept;
  logic             unused_bits;

  assign a_mag_full  = sm_mag((MAX_W+1)'(a), MAG_W);
  assign b_mag_full  = sm_mag((MAX_W+1)'(b), MAG_W);
  assign a_mag       = a_mag_full[MAG_W-1:0];
  assign b_mag       = b_mag_full[MAG_W-1:0];
  assign unused_bits = ^{a_mag_full[MAX_W-1:MAG_W], b_mag_full[MAX_W-1:MAG_W]};
  assign sign_in     = sm_sign((MAX_W+1)'(a), MAG_W) ^ sm_sign((MAX_W+1)'(b), MAG_W);
  assign zero_in     = (a_mag == '0) || (b_mag == '0);

  // DONE lets a new pair in on the same edge the result is taken.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  sm_mult_step #(
    .MAG_W(MAG_W),
    .STEP (STEP)
  ) u_step (
    .mcand    (mcand),
    .mplier_lo(mplier[STEP-1:0]),
    .acc      (acc),
    .acc_next (acc_next)
  );

  // An accept overrides the DONE hand-off below, so the result and a new load share one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sign_r    <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      prdct     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << STEP;
          mplier <= mplier >> STEP;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            prdct     <= {sign_r, acc_next};
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        ZERO: begin
          prdct     <= '0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        sign_r <= sign_in;
        mcand  <= {{MAG_W{1'b0}}, a_mag};
        mplier <= b_mag;
        acc    <= '0;
        cnt    <= CNT_INIT;
        busy   <= !zero_in;
        state  <= zero_in ? ZERO : CALC;
      end
    end
  end

endmodule

// File: tb/tb_sm_mult_seq.sv
// Directed and random checks of sm_mult_seq at MAG_W=8 with STEP = 1, 2 and 4.
module tb_sm_mult_seq;

  typedef struct {
    logic [8:0]  a;
    logic [8:0]  b;
    logic [16:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  in_valid, in_ready, out_valid, out_ready, busy;
  logic [8:0]  a [3];
  logic [8:0]  b [3];
  logic [16:0] prdct [3];

  int checks = 0;
  int errors = 0;
  vec_t vecs [10];

  sm_mult_seq #(.MAG_W(8), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .prdct(prdct[0]), .busy(busy[0]));

  sm_mult_seq #(.MAG_W(8), .STEP(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .prdct(prdct[1]), .busy(busy[1]));

  sm_mult_seq #(.MAG_W(8), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .prdct(prdct[2]), .busy(busy[2]));

  always #5 clk = ~clk;

  function automatic int step_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic logic [16:0] model(input logic [8:0] av, input logic [8:0] bv);
    logic [15:0] m;
    m = av[7:0] * bv[7:0];
    return (m == 16'h0) ? 17'h0 : {av[8] ^ bv[8], m};
  endfunction

  function automatic bit is_zero(input logic [8:0] av, input logic [8:0] bv);
    return (av[7:0] == 8'h0) || (bv[7:0] == 8'h0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; presents one pair and returns after the accept edge.
  task automatic applyStimulus(input int k, input logic [8:0] av, input logic [8:0] bv);
    check($sformatf("in_ready s%0d", step_of(k)), 32'(in_ready[k]), 32'd1);
    a[k] = av;
    b[k] = bv;
    in_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
  endtask

  // Latency counts the accept edge as edge 1.
  task automatic checkOutput(input int k, input string tag, input logic [16:0] exp,
                             input int exp_lat, input int exp_busy);
    int edges;
    int busy_cnt;
    edges = 1;
    busy_cnt = 0;
    while (!out_valid[k] && edges < 40) begin
      if (busy[k]) busy_cnt++;
      @(posedge clk);
      #1;
      edges++;
    end
    check($sformatf("%s s%0d latency", tag, step_of(k)), 32'(edges), 32'(exp_lat));
    check($sformatf("%s s%0d prdct", tag, step_of(k)), 32'(prdct[k]), 32'(exp));
    check($sformatf("%s s%0d busy cycles", tag, step_of(k)), 32'(busy_cnt), 32'(exp_busy));
  endtask

  task automatic takeResult(input int k);
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
    check($sformatf("out_valid cleared s%0d", step_of(k)), 32'(out_valid[k]), 32'd0);
  endtask

  task automatic runOp(input int k, input string tag, input logic [8:0] av,
                       input logic [8:0] bv, input logic [16:0] exp);
    int n;
    n = 8 / step_of(k);
    applyStimulus(k, av, bv);
    if (is_zero(av, bv)) checkOutput(k, tag, exp, 2, 0);
    else                 checkOutput(k, tag, exp, n + 1, n);
    takeResult(k);
  endtask

  initial begin
    logic [8:0] ra, rb;
    in_valid  = '0;
    out_ready = '0;
    for (int k = 0; k < 3; k++) begin
      a[k] = '0;
      b[k] = '0;
    end

    vecs[0] = '{9'h005, 9'h103, 17'h1000F};
    vecs[1] = '{9'h1FF, 9'h1FF, 17'h0FE01};
    vecs[2] = '{9'h100, 9'h17B, 17'h00000};
    vecs[3] = '{9'h0FF, 9'h001, 17'h000FF};
    vecs[4] = '{9'h101, 9'h0FF, 17'h100FF};
    vecs[5] = '{9'h080, 9'h080, 17'h04000};
    vecs[6] = '{9'h000, 9'h000, 17'h00000};
    vecs[7] = '{9'h07B, 9'h100, 17'h00000};
    vecs[8] = '{9'h10A, 9'h00C, 17'h10078};
    vecs[9] = '{9'h1C8, 9'h064, 17'h14E20};

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset out_valid s%0d", step_of(k)), 32'(out_valid[k]), 32'd0);
      check($sformatf("reset prdct s%0d", step_of(k)), 32'(prdct[k]), 32'd0);
      check($sformatf("reset busy s%0d", step_of(k)), 32'(busy[k]), 32'd0);
      check($sformatf("reset in_ready s%0d", step_of(k)), 32'(in_ready[k]), 32'd1);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 3; k++)
      for (int v = 0; v < 10; v++)
        runOp(k, $sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].exp);

    // Back-pressure: result must hold while a new pair waits, then pass through with no idle cycle.
    applyStimulus(0, 9'h005, 9'h103);
    checkOutput(0, "bp first", 17'h1000F, 9, 8);
    a[0] = 9'h0FF;
    b[0] = 9'h001;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp in_ready held low", 32'(in_ready[0]), 32'd0);
      @(posedge clk);
      #1;
      check("bp out_valid held", 32'(out_valid[0]), 32'd1);
      check("bp prdct held", 32'(prdct[0]), 32'h1000F);
    end
    out_ready[0] = 1'b1;
    #1;
    check("bp in_ready follows out_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    check("bp out_valid after take", 32'(out_valid[0]), 32'd0);
    check("bp busy after pass-through", 32'(busy[0]), 32'd1);
    checkOutput(0, "bp second", 17'h000FF, 9, 8);
    takeResult(0);

    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 1000; r++) begin
        ra = 9'($urandom);
        rb = 9'($urandom);
        if ($urandom_range(0, 15) == 0) ra[7:0] = 8'h0;
        runOp(k, "rand", ra, rb, model(ra, rb));
      end

    // Leave a nonzero result in prdct, then reset part-way through a new multiply.
    runOp(0, "pre-reset", 9'h0FF, 9'h001, 17'h000FF);
    applyStimulus(0, 9'h005, 9'h0FF);
    repeat (3) @(posedge clk);
    #1;
    check("busy before reset", 32'(busy[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset mid-op out_valid", 32'(out_valid[0]), 32'd0);
    check("reset mid-op prdct", 32'(prdct[0]), 32'd0);
    check("reset mid-op busy", 32'(busy[0]), 32'd0);
    check("reset mid-op in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    runOp(0, "post-reset", 9'h1C8, 9'h064, 17'h14E20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_mult_seq.md
Name: sm_mult_seq

Overview:
- Parametrised sequential sign-magnitude multiplier with valid/ready handshakes on both input and output.
- Computes the magnitude by iterative shift-add, STEP bits per cycle, and the sign by XOR of the operand signs.
- Zero-magnitude operands take a one-cycle fast path.
- Sits in the FFT butterfly datapath as the generalised replacement for the fixed 8-bit magnitude multiplier wrappers.

Parameters:
- MAG_W, 8, magnitude width of each operand (excluding sign); must be at least 2.
- STEP, 1, multiplier bits retired per CALC cycle; must be 1, 2 or 4 and must divide MAG_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands a, b are valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  MAG_W+1  operand A; MSB is the sign (1 = negative), low MAG_W bits are the magnitude.
- b  in  MAG_W+1  operand B; same format as a.
- out_valid  out  1  prdct holds a completed product.
- out_ready  in  1  consumer accepts prdct.
- prdct  out  2*MAG_W+1  product; MSB is the sign, low 2*MAG_W bits are the magnitude.
- busy  out  1  high in CALC.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state = IDLE, out_valid = 0, prdct = 0, busy = 0, accumulator/shift registers = 0. in_ready is combinational and therefore 1 out of reset.
- Accept: an input transfer occurs on a rising edge with in_valid & in_ready. On that edge the block latches:
  - sign_r = a[MAG_W] ^ b[MAG_W]
  - mcand = a magnitude, zero-extended to 2*MAG_W
  - mplier = b magnitude
  - acc = 0
  - cnt = MAG_W/STEP - 1
- States:
  - IDLE: in_ready = 1. On accept, go to ZERO if either magnitude is 0, otherwise go to CALC.
  - CALC: in_ready = 0, busy = 1. Each cycle:
    - acc += sum over i < STEP of (mplier[i] ? mcand << i : 0)
    - mcand <<= STEP
    - mplier >>= STEP
    - cnt decrements
    - When cnt == 0, load prdct = {sign_r, acc_next}, set out_valid = 1 and go to DONE.
  - ZERO: a single cycle. prdct = 0 (sign forced to 0, so -0 is never produced), out_valid = 1, go to DONE.
  - DONE: out_valid = 1 and prdct is held stable until an output transfer (out_valid & out_ready).
    - in_ready = out_ready, so a new operand pair can be accepted on the same edge the result is taken.
    - On that edge, with a simultaneous accept, go to CALC or ZERO as appropriate; otherwise go to IDLE with out_valid = 0.
- Latency (accept edge to the first edge after which out_valid is high):
  - MAG_W/STEP + 1 edges for a nonzero product.
  - 2 edges for the zero path.
- Throughput: one product every MAG_W/STEP + 1 cycles when out_ready is held high.
- Arithmetic: exact; no overflow is possible because MAG_W x MAG_W fits in 2*MAG_W bits. The acc add is unsigned at width 2*MAG_W.
- Back-pressure: prdct and out_valid must not change while out_valid & !out_ready.
- Inputs are ignored when in_ready = 0; there is no queuing.
- Asynchronous reset mid-operation aborts the computation immediately and returns all state and outputs to reset values. No partial result is emitted.
- in_valid may drop without an accept; no state change results.

Decomposition:
- Shared package sm_arith_pkg holds:
  - the state enum (IDLE, CALC, ZERO, DONE)
  - localparam helpers PRD_W = 2*MAG_W+1 and N_ITER = MAG_W/STEP
  - the sign-magnitude field-extract functions (sm_sign, sm_mag)
- One natural sub-module, sm_mult_step: combinational partial-product adder taking mcand, the low STEP bits of mplier and acc, and returning acc_next. This isolates the STEP generalisation from the control FSM.

Test Plan:
1. MAG_W=8, STEP=1. Accept a=9'h005 (+5), b=9'h103 (-3) at edge 0 -> out_valid high after edge 9, prdct=17'h1000F (-15), busy high during edges 1..8.
2. MAG_W=8, STEP=1. a=9'h1FF (-255), b=9'h1FF (-255) -> prdct=17'h0FE01 (+65025). Checks maximum magnitude and that negative x negative is positive.
3. Zero path. a=9'h100 (-0), b=9'h17B -> out_valid high after edge 2 with prdct=17'h00000; busy never asserted.
4. Back-pressure and pass-through. Hold out_ready=0 for 5 cycles after a result: prdct stays stable and in_ready stays 0. Then raise out_ready with in_valid=1 and a new pair -> result is taken and the new pair is accepted on the same edge, with no idle cycle.
5. MAG_W=8, STEP=2 and STEP=4. Same operands as scenario 1 -> identical prdct, with latency 5 and 3 edges respectively. Also run 1000 random operand pairs against a reference model.
6. Reset mid-operation. Deassert rst_n asynchronously (between clock edges) at CALC cycle 4 -> out_valid=0, prdct=0, busy=0 immediately. After release, in_ready=1 and a fresh multiply completes correctly.
